// File: rtl/iiitb_fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// Imported by the arbiter top and its priority picker.
package iiitb_fifo_wr_arb_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int N_REQ_DEF     = 4;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_st_e;

  // Index after cur, wrapping at n.
  function automatic logic [2:0] rr_next(
    input logic [2:0] cur,
    input int         n
  );
    int v;
    v = int'(cur) + 1;
    if (v >= n) v = 0;
    return 3'(v);
  endfunction

endpackage

// File: rtl/iiitb_fifo_wr_arb_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after base.
// Purely combinational; base must be below N_REQ.
module iiitb_rr_pick
  import iiitb_fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       base,
  output logic             any,
  output logic [2:0]       idx
);

  // Scan base, base+1, ... and keep the first requester.
  always_comb begin
    any = 1'b0;
    idx = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && req[i] &&
            i == (int'(base) + k) % N_REQ) begin
          any = 1'b1;
          idx = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/iiitb_fifo_wr_arb.sv
// Round-robin burst arbiter for a shared FIFO write port.
// One owner at a time, writes gated by buf_full.
module iiitb_fifo_wr_arb
  import iiitb_fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        ack,
  input  logic                    buf_full,
  output logic                    wr_en,
  output logic [DATA_W-1:0]       buf_in,
  output logic [2:0]              grant_id,
  output logic                    busy
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  arb_st_e    st, st_d;
  logic [2:0] owner, owner_d;
  logic [2:0] rr_ptr, rr_d;
  logic [3:0] beat_cnt, beat_d;

  logic       req_own;
  logic       pick_any;
  logic [2:0] pick_idx;

  iiitb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req  (req),
    .base (rr_ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Select the owner's request and word.
  always_comb begin
    req_own = 1'b0;
    buf_in  = data_in[DATA_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == 3'(i)) begin
        req_own = req[i];
        buf_in  = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write strobe and one-hot ack for the owner.
  always_comb begin
    wr_en = (st == ST_BURST) & req_own & ~buf_full;
    ack   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = wr_en && (owner == 3'(i));
    end
  end

  assign grant_id = owner;
  assign busy     = (st == ST_BURST);

  // Next state: grant in IDLE, count beats and close in BURST.
  always_comb begin
    st_d    = st;
    owner_d = owner;
    rr_d    = rr_ptr;
    beat_d  = beat_cnt;
    unique case (st)
      ST_IDLE: begin
        if (pick_any && !buf_full) begin
          st_d    = ST_BURST;
          owner_d = pick_idx;
          beat_d  = 4'd0;
        end
      end
      ST_BURST: begin
        if (!req_own ||
            (wr_en && beat_cnt == LAST_BEAT)) begin
          st_d   = ST_IDLE;
          rr_d   = rr_next(owner, N_REQ);
          beat_d = 4'd0;
        end else if (wr_en) begin
          beat_d = beat_cnt + 4'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= ST_IDLE;
      owner    <= 3'd0;
      rr_ptr   <= 3'd0;
      beat_cnt <= 4'd0;
    end else begin
      st       <= st_d;
      owner    <= owner_d;
      rr_ptr   <= rr_d;
      beat_cnt <= beat_d;
    end
  end

endmodule

// File: tb/tb_iiitb_fifo_wr_arb.sv
// Directed bench for the FIFO write arbiter.
// Producers and an 8-deep FIFO are modelled with queues.
module tb_iiitb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic        buf_full;
  logic        wr_en;
  logic [7:0]  buf_in;
  logic [2:0]  grant_id;
  logic        busy;

  iiitb_fifo_wr_arb #(
    .N_REQ(4), .DATA_W(8), .BURST_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .buf_full (buf_full),
    .wr_en    (wr_en),
    .buf_in   (buf_in),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] pq [4][$];
  logic [7:0] fq [$];
  bit         hold [4];
  bit         pop_en;
  int         wlog_p [$];
  logic [7:0] wlog_d [$];
  int         wlog_c [$];
  int         hot_err;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = (pq[i].size() > 0) && !hold[i];
      data_in[i*8 +: 8] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
    buf_full = (fq.size() >= 8);
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic step();
    logic [3:0] a;
    logic       w;
    logic [7:0] d;
    bit         p;
    int         who;
    a = ack; w = wr_en; d = buf_in; p = pop_en;
    if ($countones(a) > 1) hot_err++;
    @(posedge clk);
    who = -1;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) begin
        void'(pq[i].pop_front());
        who = i;
      end
    end
    if (p && fq.size() > 0) void'(fq.pop_front());
    if (w) begin
      fq.push_back(d);
      wlog_p.push_back(who);
      wlog_d.push_back(d);
      wlog_c.push_back(cyc);
    end
    cyc++;
    #1;
    settle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      hold[i] = 0;
    end
    fq.delete();
    wlog_p.delete(); wlog_d.delete(); wlog_c.delete();
    pop_en = 0;
    hot_err = 0;
    settle();
    step();
    step();
    rst = 1'b1;
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      pq[i].push_back(8'(16*i + 1));
      hold[i] = 0;
    end
    fq.delete();
    pop_en = 0;
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
      tests++; if (ack !== 4'h0) begin fails++; $display("FAIL rst_ack: got %h want 0", ack); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      step();
    end
    tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    tests++; if (buf_in !== 8'h01) begin fails++; $display("FAIL rst_buf_in: got %h want 01", buf_in); end
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rel_busy0: got %b want 0", busy); end
    step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rel_busy1: got %b want 1", busy); end
    tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL rel_grant: got %0d want 0", grant_id); end
    tests++; if (ack !== 4'b0001) begin fails++; $display("FAIL rel_ack: got %b want 0001", ack); end
  endtask

  task automatic test_single();
    logic [3:0] e_ack  [7] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2};
    logic       e_busy [7] = '{0, 1, 1, 1, 1, 0, 1};
    logic [7:0] e_dat  [7] = '{8'd0, 8'd11, 8'd12, 8'd13, 8'd14, 8'd0, 8'd15};
    do_reset();
    for (int k = 11; k <= 15; k++) pq[1].push_back(8'(k));
    settle();
    for (int c = 0; c < 7; c++) begin
      tests++; if (ack !== e_ack[c]) begin fails++; $display("FAIL single_ack c%0d: got %b want %b", c, ack, e_ack[c]); end
      tests++; if (busy !== e_busy[c]) begin fails++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, e_busy[c]); end
      if (e_ack[c] != 4'h0) begin
        tests++; if (buf_in !== e_dat[c]) begin fails++; $display("FAIL single_data c%0d: got %0d want %0d", c, buf_in, e_dat[c]); end
        tests++; if (grant_id !== 3'd1) begin fails++; $display("FAIL single_grant c%0d: got %0d want 1", c, grant_id); end
      end
      step();
    end
    tests++; if (fq.size() !== 5) begin fails++; $display("FAIL single_fifo_cnt: got %0d want 5", fq.size()); end
    for (int k = 0; k < 5 && k < fq.size(); k++) begin
      tests++; if (fq[k] !== 8'(11 + k)) begin fails++; $display("FAIL single_pop%0d: got %0d want %0d", k, fq[k], 11 + k); end
    end
  endtask

  task automatic test_all_four();
    int n;
    int ep;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(8'(16*i + k));
    pop_en = 1;
    settle();
    n = 0;
    while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()) > 0 && n < 200) begin
      step();
      n++;
    end
    tests++; if (n >= 200) begin fails++; $display("FAIL all4_timeout: got %0d cycles want < 200", n); end
    tests++; if (wlog_p.size() !== 32) begin fails++; $display("FAIL all4_count: got %0d want 32", wlog_p.size()); end
    for (int w = 0; w < 32 && w < wlog_p.size(); w++) begin
      ep = (w / 4) % 4;
      ed = 8'(16*ep + (w / 16) * 4 + w % 4);
      tests++; if (wlog_p[w] !== ep || wlog_d[w] !== ed) begin
        fails++; $display("FAIL all4_w%0d: got p%0d/%h want p%0d/%h", w, wlog_p[w], wlog_d[w], ep, ed);
      end
    end
    if (wlog_c.size() == 32) begin
      tests++; if (wlog_c[31] !== 39) begin fails++; $display("FAIL all4_last_cycle: got %0d want 39", wlog_c[31]); end
    end
    tests++; if (hot_err !== 0) begin fails++; $display("FAIL all4_onehot: got %0d bad cycles want 0", hot_err); end
    pop_en = 0;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 5; k++) fq.push_back(8'(8'h50 + k));
    for (int k = 0; k < 4; k++) pq[1].push_back(8'(8'hA0 + k));
    settle();
    for (int c = 1; c <= 3; c++) begin
      step();
      tests++; if (ack !== 4'b0010 || buf_in !== 8'(8'hA0 + c - 1)) begin
        fails++; $display("FAIL full_fill c%0d: got %b/%h want 0010/%h", c, ack, buf_in, 8'(8'hA0 + c - 1));
      end
    end
    step();
    for (int c = 4; c <= 5; c++) begin
      tests++; if (buf_full !== 1'b1) begin fails++; $display("FAIL full_flag c%0d: got %b want 1", c, buf_full); end
      tests++; if (wr_en !== 1'b0 || ack !== 4'h0) begin fails++; $display("FAIL full_stall c%0d: got %b/%b want 0/0000", c, wr_en, ack); end
      tests++; if (busy !== 1'b1 || grant_id !== 3'd1) begin fails++; $display("FAIL full_hold c%0d: got %b/%0d want 1/1", c, busy, grant_id); end
      if (c == 4) step();
    end
    pop_en = 1;
    settle();
    step();
    pop_en = 0;
    settle();
    tests++; if (wr_en !== 1'b1 || ack !== 4'b0010 || buf_in !== 8'hA3) begin
      fails++; $display("FAIL full_resume: got %b/%b/%h want 1/0010/a3", wr_en, ack, buf_in);
    end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_end: got %b want 0", busy); end
    tests++; if (fq.size() !== 8 || fq[fq.size()-1] !== 8'hA3) begin
      fails++; $display("FAIL full_tail: got n%0d/%h want n8/a3", fq.size(), fq[fq.size()-1]);
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int k = 0; k < 5; k++) pq[1].push_back(8'(8'hB0 + k));
    pq[3].push_back(8'hD0);
    settle();
    step();
    tests++; if (grant_id !== 3'd1 || ack !== 4'b0010) begin fails++; $display("FAIL drop_grant1: got %0d/%b want 1/0010", grant_id, ack); end
    step();
    tests++; if (buf_in !== 8'hB1) begin fails++; $display("FAIL drop_w2: got %h want b1", buf_in); end
    step();
    hold[1] = 1;
    pq[0].push_back(8'hC0);
    settle();
    tests++; if (wr_en !== 1'b0 || ack !== 4'h0) begin fails++; $display("FAIL drop_nowrite: got %b/%b want 0/0000", wr_en, ack); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_idle: got %b want 0", busy); end
    step();
    tests++; if (busy !== 1'b1 || grant_id !== 3'd3) begin fails++; $display("FAIL drop_next: got %b/%0d want 1/3", busy, grant_id); end
    tests++; if (ack !== 4'b1000 || buf_in !== 8'hD0) begin fails++; $display("FAIL drop_next_ack: got %b/%h want 1000/d0", ack, buf_in); end
  endtask

  task automatic test_async_rst();
    do_reset();
    for (int k = 0; k < 4; k++) pq[0].push_back(8'(8'hE0 + k));
    settle();
    step();
    step();
    step();
    tests++; if (wr_en !== 1'b1 || buf_in !== 8'hE2) begin fails++; $display("FAIL arst_beat3: got %b/%h want 1/e2", wr_en, buf_in); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (wr_en !== 1'b0 || ack !== 4'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL arst_drop: got %b/%b/%b want 0/0000/0", wr_en, ack, busy);
    end
    step();
    tests++; if (fq.size() !== 2) begin fails++; $display("FAIL arst_fifo_cnt: got %0d want 2", fq.size()); end
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_rel_idle: got %b want 0", busy); end
    step();
    tests++; if (busy !== 1'b1 || grant_id !== 3'd0 || ack !== 4'b0001 || buf_in !== 8'hE2) begin
      fails++; $display("FAIL arst_regrant: got %b/%0d/%b/%h want 1/0/0001/e2", busy, grant_id, ack, buf_in);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    data_in = '0;
    buf_full = 1'b0;
    pop_en = 0;
    hot_err = 0;
    test_reset();
    test_single();
    test_all_four();
    test_full();
    test_drop();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
